// File: rtl/reset_seq_pkg.sv
// Shared state encoding and sizing helpers for the staged reset sequencer.
// The sizing helpers keep the counter and domain index widths consistent between files.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT,
        DONE,
        ERROR
    } seqState_t;

    // The counter is sized to hold the larger of the hold period and the init timeout.
    function automatic int counterWidth(input int holdCycles, input int timeoutCycles);
        int maxCycles;
        maxCycles = (holdCycles > timeoutCycles) ? holdCycles : timeoutCycles;
        return $clog2(maxCycles + 1);
    endfunction

    function automatic int indexWidth(input int numDomains);
        return (numDomains > 1) ? $clog2(numDomains) : 1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating up-counter with clear, compared against a runtime limit.
// It is shared by the hold period and the per-domain init timeout.
module seq_timer
    import reset_seq_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    // Stops at the limit so the count can never wrap, even if the FSM lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == i_limit);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains in reset, then releases them one at a time,
// waiting for each domain's ready flag under a timeout; a soft-reset pulse restarts everything.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter  int NUM_DOMAINS  = 4,
    parameter  int RESET_CYCLES = 30,
    parameter  int INIT_TIMEOUT = 1023,
    localparam int IDX_W        = indexWidth(NUM_DOMAINS),
    localparam int CNT_W        = counterWidth(RESET_CYCLES, INIT_TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   softResetReq,
    input  logic [NUM_DOMAINS-1:0] domainReady,
    output logic [NUM_DOMAINS-1:0] domainRst,
    output logic                   allReady,
    output logic                   busy,
    output logic                   timeoutErr,
    output logic [IDX_W-1:0]       failedDomain
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    seqState_t              r_state, w_nextState;
    logic [IDX_W-1:0]       r_idx, w_nextIdx;
    logic [NUM_DOMAINS-1:0] r_domainRst, w_nextDomainRst;
    logic                   r_allReady, w_nextAllReady;
    logic                   r_busy, w_nextBusy;
    logic                   r_timeoutErr, w_nextTimeoutErr;
    logic [IDX_W-1:0]       r_failedDomain, w_nextFailedDomain;

    logic                   w_timerClear;
    logic                   w_timerEnable;
    logic                   w_timerTerminal;
    logic [CNT_W-1:0]       w_timerLimit;
    logic                   w_idxReady;
    logic                   w_anyDrop;
    logic [IDX_W-1:0]       w_lowestDrop;

    assign w_timerLimit = (r_state == HOLD) ? HOLD_LIMIT : WAIT_LIMIT;
    assign w_anyDrop    = ~&domainReady;

    seq_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timerClear),
        .i_enable  (w_timerEnable),
        .i_limit   (w_timerLimit),
        .o_terminal(w_timerTerminal)
    );

    // Scanning downwards leaves the lowest dropped index as the final assignment.
    always_comb begin
        w_idxReady   = 1'b0;
        w_lowestDrop = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (r_idx == IDX_W'(i)) begin
                w_idxReady = domainReady[i];
            end
            if (!domainReady[i]) begin
                w_lowestDrop = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_timerClear  = 1'b0;
        w_timerEnable = 1'b0;
        if (softResetReq) begin
            w_nextState  = HOLD;
            w_timerClear = 1'b1;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_timerTerminal) begin
                        w_nextState  = WAIT;
                        w_timerClear = 1'b1;
                    end else begin
                        w_timerEnable = 1'b1;
                    end
                end
                WAIT: begin
                    if (w_idxReady) begin
                        w_timerClear = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_nextState = DONE;
                        end
                    end else if (w_timerTerminal) begin
                        w_nextState  = ERROR;
                        w_timerClear = 1'b1;
                    end else begin
                        w_timerEnable = 1'b1;
                    end
                end
                DONE: begin
                    if (w_anyDrop) begin
                        w_nextState = ERROR;
                    end
                end
                ERROR: ;
                default: w_nextState = HOLD;
            endcase
        end
    end

    always_comb begin
        w_nextIdx          = r_idx;
        w_nextDomainRst    = r_domainRst;
        w_nextAllReady     = r_allReady;
        w_nextBusy         = r_busy;
        w_nextTimeoutErr   = r_timeoutErr;
        w_nextFailedDomain = r_failedDomain;
        if (softResetReq) begin
            w_nextIdx          = '0;
            w_nextDomainRst    = '1;
            w_nextAllReady     = 1'b0;
            w_nextBusy         = 1'b1;
            w_nextTimeoutErr   = 1'b0;
            w_nextFailedDomain = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_timerTerminal) begin
                        w_nextIdx          = '0;
                        w_nextDomainRst[0] = 1'b0;
                    end
                end
                WAIT: begin
                    if (w_idxReady) begin
                        if (r_idx == LAST_IDX) begin
                            w_nextAllReady = 1'b1;
                            w_nextBusy     = 1'b0;
                        end else begin
                            w_nextIdx       = r_idx + 1'b1;
                            w_nextDomainRst = r_domainRst & ~(NUM_DOMAINS'(1) << (r_idx + 1'b1));
                        end
                    end else if (w_timerTerminal) begin
                        w_nextTimeoutErr   = 1'b1;
                        w_nextFailedDomain = r_idx;
                        w_nextBusy         = 1'b0;
                    end
                end
                DONE: begin
                    if (w_anyDrop) begin
                        w_nextAllReady     = 1'b0;
                        w_nextTimeoutErr   = 1'b1;
                        w_nextFailedDomain = w_lowestDrop;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= HOLD;
            r_idx          <= '0;
            r_domainRst    <= '1;
            r_allReady     <= 1'b0;
            r_busy         <= 1'b1;
            r_timeoutErr   <= 1'b0;
            r_failedDomain <= '0;
        end else begin
            r_state        <= w_nextState;
            r_idx          <= w_nextIdx;
            r_domainRst    <= w_nextDomainRst;
            r_allReady     <= w_nextAllReady;
            r_busy         <= w_nextBusy;
            r_timeoutErr   <= w_nextTimeoutErr;
            r_failedDomain <= w_nextFailedDomain;
        end
    end

    assign domainRst    = r_domainRst;
    assign allReady     = r_allReady;
    assign busy         = r_busy;
    assign timeoutErr   = r_timeoutErr;
    assign failedDomain = r_failedDomain;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a small domain model answers each release with a ready flag,
// and expected output snapshots are queued by edge number and compared as edges occur.
module tb_reset_sequencer;

    localparam int ND          = 3;
    localparam int RC          = 4;
    localparam int IT          = 8;
    localparam int ENV_DELAY   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          softResetReq = 1'b0;
    logic [ND-1:0] domainReady = '0;
    logic [ND-1:0] domainRst;
    logic          allReady;
    logic          busy;
    logic          timeoutErr;
    logic [1:0]    failedDomain;

    reset_sequencer #(
        .NUM_DOMAINS (ND),
        .RESET_CYCLES(RC),
        .INIT_TIMEOUT(IT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .softResetReq(softResetReq),
        .domainReady (domainReady),
        .domainRst   (domainRst),
        .allReady    (allReady),
        .busy        (busy),
        .timeoutErr  (timeoutErr),
        .failedDomain(failedDomain)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int         edgeNo;
        logic [2:0] dRst;
        logic       allRdy;
        logic       busyV;
        logic       tErr;
        logic [1:0] fDom;
    } expSnap_t;

    expSnap_t sb[$];
    int       errors = 0;
    int       checks = 0;
    int       relCnt[ND];
    logic [ND-1:0] readyEnable = '1;
    logic [ND-1:0] forceReady  = '0;
    logic [ND-1:0] dropMask    = '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic pushExp(input int edgeNo, input logic [2:0] dRst, input logic allRdy,
                           input logic busyV, input logic tErr, input logic [1:0] fDom);
        expSnap_t e;
        e.edgeNo = edgeNo;
        e.dRst   = dRst;
        e.allRdy = allRdy;
        e.busyV  = busyV;
        e.tErr   = tErr;
        e.fDom   = fDom;
        sb.push_back(e);
    endtask

    // Normal bring-up counted from the edge that put the sequencer into HOLD with a cleared count.
    task automatic pushBringUp(input int base);
        pushExp(base + RC - 1,                 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC,                     3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC + ENV_DELAY - 1,     3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC + ENV_DELAY,         3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC + 2*ENV_DELAY - 1,   3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC + 2*ENV_DELAY,       3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC + 3*ENV_DELAY - 1,   3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(base + RC + 3*ENV_DELAY,       3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic driveReady();
        logic [ND-1:0] envReady;
        for (int i = 0; i < ND; i++) begin
            envReady[i] = (relCnt[i] >= ENV_DELAY);
        end
        domainReady = ((envReady & readyEnable) | forceReady) & ~dropMask;
    endtask

    task automatic stepCycle();
        expSnap_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].edgeNo <= cycle) begin
            e = sb.pop_front();
            if (e.edgeNo < cycle) begin
                checkOutput("late_expectation", cycle, e.edgeNo);
            end else begin
                checkOutput($sformatf("e%0d_domainRst", e.edgeNo), domainRst, e.dRst);
                checkOutput($sformatf("e%0d_allReady", e.edgeNo), allReady, e.allRdy);
                checkOutput($sformatf("e%0d_busy", e.edgeNo), busy, e.busyV);
                checkOutput($sformatf("e%0d_timeoutErr", e.edgeNo), timeoutErr, e.tErr);
                checkOutput($sformatf("e%0d_failedDomain", e.edgeNo), failedDomain, e.fDom);
            end
        end
        for (int i = 0; i < ND; i++) begin
            if (domainRst[i] !== 1'b0) relCnt[i] = 0;
            else if (relCnt[i] < 15) relCnt[i] = relCnt[i] + 1;
        end
        driveReady();
    endtask

    task automatic applyStimulus(input logic rstV, input logic softV);
        rst          = rstV;
        softResetReq = softV;
        stepCycle();
        softResetReq = 1'b0;
    endtask

    task automatic runUntil(input int edgeNo);
        while (cycle < edgeNo) stepCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p, q, d, r, s, t, u, v;
        expSnap_t e;
        for (int i = 0; i < ND; i++) relCnt[i] = 0;
        driveReady();

        // Normal bring-up after two reset cycles.
        pushExp(2, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushBringUp(2);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        runUntil(17);

        // Domain 1 never comes ready; the mask change coincides with the soft pulse.
        readyEnable = 3'b101;
        driveReady();
        p = cycle + 1;
        pushExp(p,      3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(p + 3,  3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(p + 4,  3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(p + 7,  3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(p + 14, 3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(p + 15, 3'b100, 1'b0, 1'b0, 1'b1, 2'd1);
        pushExp(p + 35, 3'b100, 1'b0, 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b1);
        runUntil(p + 35);

        // Soft reset out of ERROR repeats the normal timing.
        readyEnable = 3'b111;
        driveReady();
        q = cycle + 1;
        pushExp(q, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushBringUp(q);
        applyStimulus(1'b0, 1'b1);
        runUntil(q + 15);

        // One-cycle drop of domain 2 while DONE.
        d = cycle + 1;
        dropMask = 3'b100;
        driveReady();
        pushExp(d,     3'b000, 1'b0, 1'b0, 1'b1, 2'd2);
        pushExp(d + 3, 3'b000, 1'b0, 1'b0, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b0);
        dropMask = '0;
        driveReady();
        runUntil(d + 3);

        // Soft pulse on the same edge that samples domainReady[0] high.
        r = cycle + 1;
        pushExp(r,     3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(r + 4, 3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(r + 7, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushBringUp(r + 7);
        applyStimulus(1'b0, 1'b1);
        runUntil(r + 6);
        applyStimulus(1'b0, 1'b1);
        runUntil(r + 20);

        // Second soft pulse while HOLD count is 2 restarts the hold.
        s = cycle + 1;
        t = s + 3;
        pushExp(s,     3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(t,     3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(t + 1, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushBringUp(t);
        applyStimulus(1'b0, 1'b1);
        runUntil(t - 1);
        applyStimulus(1'b0, 1'b1);
        runUntil(t + 13);

        // All ready flags high from reset: still one release per cycle after the hold.
        forceReady = 3'b111;
        driveReady();
        u = cycle + 1;
        pushExp(u,     3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(u + 3, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(u + 4, 3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(u + 5, 3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(u + 6, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(u + 7, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        runUntil(u + 7);

        // rst in the middle of WAIT for domain 1.
        forceReady = '0;
        driveReady();
        v = cycle + 1;
        pushExp(v,     3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(v + 4, 3'b110, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(v + 7, 3'b100, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(v + 8, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        pushExp(v + 9, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1);
        runUntil(v + 7);
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        runUntil(v + 10);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("unreached_expectation", cycle, e.edgeNo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
